counter_readout_sequencer: RTL
==============================

Name: counter_readout_sequencer

Overview:
Controller that sequences readout of the multi-channel impulse counter bank. On each RTC tick it issues a one-cycle snapshot/clear strobe to the counter bank and captures all channel counts into shadow registers. It then walks the channels in order, driving the channel address, a load/shift strobe and an MSB-first serial stream to the chip pins. It also generates the global and RTC overflow flags.

Parameters:
N_CH, 8, number of counter channels (1..16; the address is fixed at 4 bits)
CNT_W, 16, width of each channel count in bits

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rtc  input  1  external RTC tick, asynchronous to clk; rising edge starts a frame
cnt_data  input  N_CH*CNT_W  flat count bus from the bank; channel i at bits [i*CNT_W +: CNT_W]
ovf_in  input  N_CH  per-channel counter overflow flags from the bank
snap  output  1  one-cycle strobe; the bank latches and clears its counters on it
addr  output  4  index of the channel currently being read out
sl  output  1  1 = load cycle for the current channel, 0 = shift or idle
serial_out  output  1  serial data, MSB first
busy  output  1  high while a frame is in progress
ovf_global  output  1  OR of ovf_in captured at the last snapshot
ovf_rtc  output  1  sticky flag: an RTC tick was dropped because a frame was in progress

Behaviour:
- Reset is asynchronous and active-high.
  - All state is cleared; FSM enters IDLE.
  - Outputs: snap=0, addr=0, sl=0, serial_out=0, busy=0, ovf_global=0, ovf_rtc=0.
  - Shadow registers, shift register and synchronizer flops are cleared.
- RTC input conditioning:
  - rtc passes through a 2-flop synchronizer, then a third flop for edge detection.
  - tick = s2 & ~s3.
  - If rtc is first sampled high at clk edge k, the FSM enters SNAP at edge k+2.
- FSM states: IDLE, SNAP, LOAD, SHIFT.
  - IDLE: busy=0, sl=0, serial_out=0, addr=0. On tick -> SNAP.
  - SNAP (1 cycle): snap=1, busy=1.
    - Shadow[i] <= cnt_data slice i for all i.
    - ovf_global <= |ovf_in.
    - ovf_rtc <= 0.
    - ch <= 0.
    - Next state: LOAD.
  - LOAD (1 cycle): sl=1, addr=ch.
    - Shift register <= shadow[ch].
    - serial_out=0.
    - bitcnt <= 0.
    - Next state: SHIFT.
  - SHIFT (CNT_W cycles): sl=0, addr=ch.
    - serial_out = shift register MSB; the register shifts left once per cycle.
    - On the last bit: if ch==N_CH-1 -> IDLE, else ch <= ch+1 and -> LOAD.
- Frame length: 1 + N_CH*(1+CNT_W) cycles. Default parameters give 137 cycles.
- Dropped ticks:
  - A tick while busy (any state other than IDLE, including the final SHIFT cycle) does not start a frame and sets ovf_rtc.
  - ovf_rtc stays set until the next SNAP or reset.
  - A tick in the same cycle as a return to IDLE is dropped.
- ovf_global holds its value between snapshots.
- Shadow registers isolate readout from the live counters; changes on cnt_data after SNAP do not affect the serial data.
- A reset mid-frame aborts immediately and no partial data is emitted. After release, the block waits for a new tick.
- A high level on rtc with no new edge does not retrigger a frame.

Optional Feature:
- Macro: READOUT_PARITY_EN.
- Defined:
  - After the CNT_W data bits of each channel, one extra SHIFT cycle outputs an even-parity bit: the XOR of that channel's CNT_W bits.
  - addr holds the current channel and sl=0 during the parity cycle.
  - Frame length becomes 1 + N_CH*(2+CNT_W). Default parameters give 145 cycles.
- Undefined: no parity cycle; frame length as above.

Test Plan:
- Reset then idle, rtc=0 for 50 cycles -> all outputs 0, snap never asserts.
- rtc rising at edge k with cnt_data ch0=0xA5C3 and ch7=0x0001 -> snap is high in exactly one cycle (edge k+2). Serial stream for ch0 is 1010010111000011 with addr=0. Last word is 0x0001 with addr=7. busy drops after 137 cycles.
- cnt_data changed immediately after snap -> serial data still matches the values captured at snap.
- Second rtc edge at cycle 60 of a frame -> no new snap, ovf_rtc=1. ovf_rtc clears at the next accepted snap.
- ovf_in=8'b0001_0000 at snap -> ovf_global=1 through the frame. Next snap with ovf_in=0 -> ovf_global=0.
- Reset asserted at cycle 40 of a frame -> outputs are 0 asynchronously. A new rtc edge after release starts a fresh frame at addr 0. With READOUT_PARITY_EN, ch0=0xA5C3 is followed by parity bit 0 (eight 1-bits).

Source files
------------

// File: rtl/counter_readout_sequencer_if.sv
// rtl/counter_readout_sequencer_if.sv - counter bank / readout pin bundle
// Purpose: groups the counter-bank inputs and readout pin outputs of the
//          counter readout sequencer.
// Signals: cnt_data   flat count bus, channel i at [i*CNT_W +: CNT_W]
//          ovf_in     per-channel overflow flags from the bank
//          snap       one-cycle latch/clear strobe to the bank
//          addr       channel being read out
//          sl         1 = load cycle, 0 = shift or idle
//          serial_out serial data, MSB first
//          busy       frame in progress
//          ovf_global OR of ovf_in at last snapshot
//          ovf_rtc    sticky dropped-tick flag
// Modports: master = sequencer, slave = counter bank / pin side.
interface counter_readout_sequencer_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16
);
  logic [N_CH*CNT_W-1:0] cnt_data;
  logic [N_CH-1:0]       ovf_in;
  logic                  snap;
  logic [3:0]            addr;
  logic                  sl;
  logic                  serial_out;
  logic                  busy;
  logic                  ovf_global;
  logic                  ovf_rtc;

  modport master (
    input  cnt_data, ovf_in,
    output snap, addr, sl, serial_out, busy, ovf_global, ovf_rtc
  );

  modport slave (
    output cnt_data, ovf_in,
    input  snap, addr, sl, serial_out, busy, ovf_global, ovf_rtc
  );
endinterface

// File: rtl/counter_readout_sequencer.sv
// rtl/counter_readout_sequencer.sv - RTC-triggered counter snapshot and serial readout
// Purpose: on each RTC rising edge, strobes snap, captures all channel counts
//          into shadow registers, then serialises each channel MSB first
//          behind a load cycle. Tracks global and dropped-tick overflow flags.
// Ports:   clk    system clock
//          reset  asynchronous active-high reset
//          rtc    RTC tick, asynchronous to clk
//          bus    counter_readout_sequencer_if.master (bank inputs, pin outputs)
// Option:  READOUT_PARITY_EN adds one even-parity bit after each channel.
module counter_readout_sequencer #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rtc,
  counter_readout_sequencer_if.master   bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
`ifdef READOUT_PARITY_EN
  localparam int N_BITS = CNT_W + 1;
`else
  localparam int N_BITS = CNT_W;
`endif
  localparam int              BC_W     = $clog2(N_BITS + 1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(N_BITS - 1);
  localparam logic [3:0]      LAST_CH  = 4'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_LOAD, S_SHIFT} state_t;

  state_t             state_q, state_d;
  logic               rtc_s1_q, rtc_s1_d;
  logic               rtc_s2_q, rtc_s2_d;
  logic               rtc_s3_q, rtc_s3_d;
  logic [3:0]         ch_q, ch_d;
  logic [BC_W-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   shadow_q [N_CH];
  logic [CNT_W-1:0]   shadow_d [N_CH];
  logic               ovf_global_q, ovf_global_d;
  logic               ovf_rtc_q, ovf_rtc_d;
`ifdef READOUT_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic       tick;
  logic       snap, sl, serial_out, busy;
  logic [3:0] addr;

  // s1/s2 resynchronise rtc; s3 is only the edge-detect history.
  assign tick = rtc_s2_q & ~rtc_s3_q;

  always_comb begin
    state_d      = state_q;
    rtc_s1_d     = rtc;
    rtc_s2_d     = rtc_s1_q;
    rtc_s3_d     = rtc_s2_q;
    ch_d         = ch_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    shadow_d     = shadow_q;
    ovf_global_d = ovf_global_q;
    ovf_rtc_d    = ovf_rtc_q;
`ifdef READOUT_PARITY_EN
    parity_d     = parity_q;
`endif
    snap         = 1'b0;
    sl           = 1'b0;
    serial_out   = 1'b0;
    busy         = 1'b0;
    addr         = 4'd0;

    // Any tick outside IDLE is dropped, including one on the final shift cycle.
    if (tick && (state_q != S_IDLE)) ovf_rtc_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_SNAP;
      end
      S_SNAP: begin
        snap = 1'b1;
        busy = 1'b1;
        for (int i = 0; i < N_CH; i++) shadow_d[i] = bus.cnt_data[i*CNT_W +: CNT_W];
        ovf_global_d = |bus.ovf_in;
        ovf_rtc_d    = 1'b0;
        ch_d         = 4'd0;
        state_d      = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        sl       = 1'b1;
        addr     = ch_q;
        shift_d  = shadow_q[ch_q[CH_W-1:0]];
`ifdef READOUT_PARITY_EN
        parity_d = ^shadow_q[ch_q[CH_W-1:0]];
`endif
        bitcnt_d = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        addr       = ch_q;
        serial_out = shift_q[CNT_W-1];
`ifdef READOUT_PARITY_EN
        // The extra trailing cycle carries the channel parity instead of data.
        if (bitcnt_q == LAST_BIT) serial_out = parity_q;
`endif
        shift_d  = {shift_q[CNT_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + 1'b1;
        if (bitcnt_q == LAST_BIT) begin
          if (ch_q == LAST_CH) begin
            state_d = S_IDLE;
          end else begin
            ch_d    = ch_q + 4'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rtc_s1_q     <= 1'b0;
      rtc_s2_q     <= 1'b0;
      rtc_s3_q     <= 1'b0;
      ch_q         <= 4'd0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
      ovf_global_q <= 1'b0;
      ovf_rtc_q    <= 1'b0;
`ifdef READOUT_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rtc_s1_q     <= rtc_s1_d;
      rtc_s2_q     <= rtc_s2_d;
      rtc_s3_q     <= rtc_s3_d;
      ch_q         <= ch_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      shadow_q     <= shadow_d;
      ovf_global_q <= ovf_global_d;
      ovf_rtc_q    <= ovf_rtc_d;
`ifdef READOUT_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.snap       = snap;
  assign bus.addr       = addr;
  assign bus.sl         = sl;
  assign bus.serial_out = serial_out;
  assign bus.busy       = busy;
  assign bus.ovf_global = ovf_global_q;
  assign bus.ovf_rtc    = ovf_rtc_q;

endmodule
